// File: rtl/triangle_adc_capture_if.sv
// Bundle between the comparator bank / refresh timing and the capture block.
// The master side drives ramp, comp and hold; the slave side returns the published codes.
interface triangle_adc_capture_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 7
);
  logic                      ramp;
  logic [CHANNELS-1:0]       comp;
  logic                      hold;
  logic [CHANNELS*WIDTH-1:0] out_value;
  logic [CHANNELS-1:0]       out_valid;
  logic                      frame_done;

  modport master (
    output ramp, comp, hold,
    input  out_value, out_valid, frame_done
  );

  modport slave (
    input  ramp, comp, hold,
    output out_value, out_valid, frame_done
  );
endinterface

// File: rtl/triangle_adc_capture.sv
// Times each comparator's fall within the triangle's rising half, giving one
// WIDTH-bit code per channel per period, with outputs frozen while hold is high.
module triangle_adc_capture #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned DIV      = 100,
  parameter int unsigned FILTER   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  triangle_adc_capture_if.slave bus
);

  localparam int unsigned PresW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FiltW = $clog2(FILTER + 1);
  localparam logic [WIDTH-1:0] CodeMax  = '1;
  localparam logic [PresW-1:0] PresLast = PresW'(DIV - 1);
  localparam logic [FiltW-1:0] FiltDone = FiltW'(FILTER);

  typedef enum logic {StIdle, StRamp} state_e;

  state_e state_q, state_d;

  logic [2:0]          ramp_sync_q;
  logic [CHANNELS-1:0] comp_s1_q, comp_s2_q;
  // Edge detection stays blind until all three ramp flops hold real pin samples,
  // so a ramp already high at reset release is not mistaken for a rising edge.
  logic [2:0]          prime_q;
  logic                ramp_rise, ramp_fall, enter, leave;

  logic [PresW-1:0] pres_q, pres_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  logic [CHANNELS-1:0]            armed_q, armed_d;
  logic [CHANNELS-1:0]            captured_q, captured_d;
  logic [CHANNELS-1:0][WIDTH-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0][FiltW-1:0] filt_q, filt_d;

  logic                      stage_q;
  logic                      frame_done_q;
  logic [CHANNELS*WIDTH-1:0] staged_val_q, out_value_q;
  logic [CHANNELS-1:0]       staged_vld_q, out_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_sync_q <= '0;
      comp_s1_q   <= '0;
      comp_s2_q   <= '0;
      prime_q     <= '0;
    end else begin
      ramp_sync_q <= {ramp_sync_q[1:0], bus.ramp};
      comp_s1_q   <= bus.comp;
      comp_s2_q   <= comp_s1_q;
      prime_q     <= {prime_q[1:0], 1'b1};
    end
  end

  assign ramp_rise = prime_q[2] & ramp_sync_q[1] & ~ramp_sync_q[2];
  assign ramp_fall = prime_q[2] & ~ramp_sync_q[1] & ramp_sync_q[2];

  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    leave   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ramp_rise) begin
          state_d = StRamp;
          enter   = 1'b1;
        end
      end
      StRamp: begin
        if (ramp_fall) begin
          state_d = StIdle;
          leave   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pres_d = pres_q;
    cnt_d  = cnt_q;
    if (enter) begin
      pres_d = '0;
      cnt_d  = '0;
    end else if (state_q == StRamp) begin
      if (pres_q == PresLast) begin
        pres_d = '0;
        if (cnt_q != CodeMax) cnt_d = cnt_q + 1'b1;
      end else begin
        pres_d = pres_q + 1'b1;
      end
    end
  end

  // Pending latches the post-edge counter value so the code equals floor(t/DIV)
  // for a fall t cycles after the rise, and a saturating tick is seen on capture.
  always_comb begin
    armed_d    = armed_q;
    captured_d = captured_q;
    pend_d     = pend_q;
    filt_d     = filt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (enter) begin
        armed_d[i]    = 1'b1;
        captured_d[i] = 1'b0;
        pend_d[i]     = '0;
        filt_d[i]     = '0;
      end else if (state_q == StRamp && armed_q[i]) begin
        if (!comp_s2_q[i]) begin
          if (filt_q[i] == '0) begin
            pend_d[i] = cnt_d;
            filt_d[i] = FiltW'(1);
          end else begin
            filt_d[i] = filt_q[i] + 1'b1;
          end
          if (filt_d[i] >= FiltDone) begin
            captured_d[i] = 1'b1;
            armed_d[i]    = 1'b0;
          end
        end else begin
          pend_d[i] = '0;
          filt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pres_q     <= '0;
      cnt_q      <= '0;
      armed_q    <= '0;
      captured_q <= '0;
      pend_q     <= '0;
      filt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pres_q     <= pres_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      captured_q <= captured_d;
      pend_q     <= pend_d;
      filt_q     <= filt_d;
    end
  end

  // Staging runs one edge after the RAMP exit so a capture completing on the
  // exit edge itself is already reflected in captured_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q      <= 1'b0;
      frame_done_q <= 1'b0;
      staged_val_q <= '0;
      staged_vld_q <= '0;
      out_value_q  <= '0;
      out_valid_q  <= '0;
    end else begin
      stage_q      <= leave;
      frame_done_q <= stage_q;
      if (stage_q) begin
        for (int i = 0; i < CHANNELS; i++) begin
          staged_val_q[i*WIDTH +: WIDTH] <= captured_q[i] ? pend_q[i] : CodeMax;
          staged_vld_q[i]                <= captured_q[i];
        end
      end
      if (!bus.hold) begin
        out_value_q <= staged_val_q;
        out_valid_q <= staged_vld_q;
      end
    end
  end

  assign bus.out_value  = out_value_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_triangle_adc_capture.sv
// Directed bench for triangle_adc_capture with DIV=4, FILTER=2: conversion, glitch
// rejection, saturation, refresh hold, mid-ramp reset and output latency.
module tb_triangle_adc_capture;

  localparam int unsigned CHANNELS = 2;
  localparam int unsigned WIDTH    = 7;
  localparam int          NEVER    = 1000000;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  triangle_adc_capture_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

  triangle_adc_capture #(
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH),
    .DIV     (4),
    .FILTER  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int ch1, input int ch0);
    logic [13:0] v;
    v = {7'(ch1), 7'(ch0)};
    return 32'(v);
  endfunction

  // One triangle period, pin-relative: ramp high for 'high' cycles then low for
  // 'low'; comp[n] falls tN cycles after the rise; comp[0] optionally dips for
  // one cycle at 'glitch0'. Outputs are sampled #1 after each edge.
  task automatic run_frame(input int high, input int low, input int t0, input int t1,
                           input int glitch0, output int pulses, output bit changed);
    logic [13:0] start_val;
    start_val = bus.out_value;
    pulses    = 0;
    changed   = 1'b0;
    for (int i = 0; i < high + low; i++) begin
      @(posedge clk);
      #1;
      bus.ramp    = (i < high);
      bus.comp[0] = !((i < high) && (i >= t0 || i == glitch0));
      bus.comp[1] = !((i < high) && (i >= t1));
      if (bus.frame_done) pulses++;
      if (bus.out_value !== start_val) changed = 1'b1;
    end
  endtask

  initial begin
    int          pulses;
    bit          changed;
    logic        fd  [6];
    logic [13:0] ov  [6];
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.ramp     = 1'b0;
    bus.comp     = '1;
    bus.hold     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_value", 32'(bus.out_value), 0);
    check_eq("reset_valid", 32'(bus.out_valid), 0);
    check_eq("reset_frame_done", 32'(bus.frame_done), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // 1: 120/4=30, 300/4=75, two periods with one pulse each
    run_frame(400, 400, 120, 300, -1, pulses, changed);
    check_eq("basic_pulses_p1", 32'(pulses), 1);
    run_frame(400, 400, 120, 300, -1, pulses, changed);
    check_eq("basic_pulses_p2", 32'(pulses), 1);
    check_eq("basic_value", 32'(bus.out_value), pack(75, 30));
    check_eq("basic_valid", 32'(bus.out_valid), 32'b11);

    // 2: one-cycle dip at 40 rejected, real fall at 200 -> 50; ch1 never falls
    run_frame(400, 20, 200, NEVER, 40, pulses, changed);
    check_eq("glitch_pulses", 32'(pulses), 1);
    check_eq("glitch_value", 32'(bus.out_value), pack(127, 50));
    check_eq("glitch_valid", 32'(bus.out_valid), 32'b01);

    // 3: ch0 low from the rise -> 0; ch1 at 900 -> 225 saturates to 127, captured
    run_frame(1000, 20, 0, 900, -1, pulses, changed);
    check_eq("minmax_value", 32'(bus.out_value), pack(127, 0));
    check_eq("minmax_valid", 32'(bus.out_valid), 32'b11);

    // 4: hold across frames coded 30 then 60; only 60 appears after release
    bus.hold = 1'b1;
    run_frame(400, 20, 120, 300, -1, pulses, changed);
    check_eq("hold_f1_pulses", 32'(pulses), 1);
    check_eq("hold_f1_frozen", 32'(changed), 0);
    run_frame(400, 20, 240, 300, -1, pulses, changed);
    check_eq("hold_f2_frozen", 32'(changed), 0);
    check_eq("hold_f2_value", 32'(bus.out_value), pack(127, 0));
    @(posedge clk);
    #1;
    bus.hold = 1'b0;
    check_eq("hold_still_old", 32'(bus.out_value), pack(127, 0));
    @(posedge clk);
    #1;
    check_eq("hold_release_value", 32'(bus.out_value), pack(75, 60));
    check_eq("hold_release_valid", 32'(bus.out_valid), 32'b11);

    // 5: reset 100 cycles into the ramp, released with ramp still high
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      bus.ramp = 1'b1;
      bus.comp = (i >= 50) ? 2'b10 : 2'b11;
    end
    reset = 1'b1;
    #1;
    check_eq("midreset_value", 32'(bus.out_value), 0);
    check_eq("midreset_valid", 32'(bus.out_valid), 0);
    check_eq("midreset_frame_done", 32'(bus.frame_done), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run_frame(200, 20, NEVER, NEVER, -1, pulses, changed);
    check_eq("midreset_no_pulse", 32'(pulses), 0);
    check_eq("midreset_valid_after", 32'(bus.out_valid), 0);
    run_frame(400, 20, 120, 300, -1, pulses, changed);
    check_eq("postreset_pulses", 32'(pulses), 1);
    check_eq("postreset_value", 32'(bus.out_value), pack(75, 30));
    check_eq("postreset_valid", 32'(bus.out_valid), 32'b11);

    // 6: latency from the ramp pin fall; codes 40/4=10, 80/4=20
    run_frame(200, 0, 40, 80, -1, pulses, changed);
    @(posedge clk);
    #1;
    bus.ramp = 1'b0;
    bus.comp = '1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      fd[k] = bus.frame_done;
      ov[k] = bus.out_value;
    end
    check_eq("lat_fd_c3", 32'(fd[3]), 0);
    check_eq("lat_fd_c4", 32'(fd[4]), 1);
    check_eq("lat_fd_c5", 32'(fd[5]), 0);
    check_eq("lat_value_c4", 32'(ov[4]), pack(75, 30));
    check_eq("lat_value_c5", 32'(ov[5]), pack(20, 10));

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
